gfx_raster_scan: RTL and testbench

Coarse-tile walker and sequencer for the fine rasterizer array. It accepts one triangle setup at a time: an inclusive bounding box in coarse-tile units, the three edge-function values at the box origin, and per-edge coarse step increments. It then walks every tile of the box row-major, driving the tile position, per-tile edge values and pipeline stall into the fine array. It also tracks occupancy of the fine pipeline so it can flag valid fine outputs and signal triangle completion.

---
 rtl/gfx_raster_scan.sv | 155 +++++++++++++++
 tb/tb_gfx_raster_scan.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_raster_scan.sv
// Coarse-tile walker for the fine rasterizer array.
// A triangle setup arrives on the in_* handshake. The walker then steps through
// its bounding box row-major, presenting one tile per advance. A shift register
// follows each tile down the fine pipeline so that tile_valid and done line up
// with the fine array's outputs.
//
// Handshake: a setup transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE, and the accept does not depend on down_ready.
// On the fine side there is no handshake. An "advance" is any rising edge with
// down_ready high (stall low). Every walker register holds its value whenever
// stall is high.
module gfx_raster_scan #(
    parameter int COARSE_BITS  = 8,
    parameter int EDGE_W       = 32,
    parameter int FINE_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [COARSE_BITS-1:0]       in_x0,
    input  logic [COARSE_BITS-1:0]       in_y0,
    input  logic [COARSE_BITS-1:0]       in_x1,
    input  logic [COARSE_BITS-1:0]       in_y1,
    input  logic [2:0][EDGE_W-1:0]       in_corners,
    input  logic [2:0][EDGE_W-1:0]       in_step_x,
    input  logic [2:0][EDGE_W-1:0]       in_step_y,
    output logic [COARSE_BITS-1:0]       pos_x,
    output logic [COARSE_BITS-1:0]       pos_y,
    output logic [2:0][EDGE_W-1:0]       corners,
    output logic                         stall,
    input  logic                         down_ready,
    output logic                         tile_valid,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WALK  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched triangle setup. y0 is not kept because a row change only
    // resets x.
    logic [COARSE_BITS-1:0] x0_q, x1_q, y1_q;
    logic [2:0][EDGE_W-1:0] step_x_q, step_y_q;
    logic [2:0][EDGE_W-1:0] row_q;

    logic [FINE_LATENCY-1:0] vld_q, vld_d;
    logic [2:0]              drain_cnt_q;
    logic                    done_q;

    logic advance, accept, degenerate, last_x, last_y, issue, drain_end;

    // Decode the conditions shared by the FSM and the datapath.
    always_comb begin
        advance    = down_ready;
        accept     = in_valid && (state_q == IDLE);
        degenerate = (in_x1 < in_x0) || (in_y1 < in_y0);
        last_x     = (pos_x == x1_q);
        last_y     = (pos_y == y1_q);
        issue      = (state_q == WALK) && advance;
        drain_end  = (state_q == DRAIN) && advance && (drain_cnt_q == 3'd0);
        vld_d      = vld_q << 1;
        vld_d[0]   = issue;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = degenerate ? DRAIN : WALK;
            end
            WALK: begin
                if (advance && last_x && last_y) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Walker datapath: setup latch, tile stepping, drain count, valid pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q        <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            step_x_q    <= '0;
            step_y_q    <= '0;
            row_q       <= '0;
            pos_x       <= '0;
            pos_y       <= '0;
            corners     <= '0;
            vld_q       <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            // done is a single-cycle pulse, even if the next cycle stalls.
            done_q <= drain_end;
            if (advance) vld_q <= vld_d;
            if (accept) begin
                x0_q        <= in_x0;
                x1_q        <= in_x1;
                y1_q        <= in_y1;
                step_x_q    <= in_step_x;
                step_y_q    <= in_step_y;
                pos_x       <= in_x0;
                pos_y       <= in_y0;
                corners     <= in_corners;
                row_q       <= in_corners;
                // An empty box only has to wait a single advance.
                drain_cnt_q <= 3'd0;
            end else if (issue) begin
                if (!last_x) begin
                    pos_x <= pos_x + COARSE_BITS'(1);
                    for (int i = 0; i < 3; i++) corners[i] <= corners[i] + step_x_q[i];
                end else if (!last_y) begin
                    pos_x <= x0_q;
                    pos_y <= pos_y + COARSE_BITS'(1);
                    for (int i = 0; i < 3; i++) begin
                        row_q[i]   <= row_q[i] + step_y_q[i];
                        corners[i] <= row_q[i] + step_y_q[i];
                    end
                end else begin
                    // Last tile issued; the count that follows lets it leave
                    // the fine pipeline.
                    drain_cnt_q <= 3'(FINE_LATENCY - 1);
                end
            end else if ((state_q == DRAIN) && advance && (drain_cnt_q != 3'd0)) begin
                drain_cnt_q <= drain_cnt_q - 3'd1;
            end
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign stall      = !down_ready;
    assign tile_valid = vld_q[FINE_LATENCY-1];
    assign done       = done_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_gfx_raster_scan.sv
// Bench for gfx_raster_scan. It uses a table of whole-triangle vectors,
// hand-written corner sequences and a randomized run. All of these are checked
// every cycle against a model that counts advances since the accept and derives
// each tile from its index in the box.
module tb_gfx_raster_scan;

    localparam int L = 2;

    logic              clk, rst_n, in_valid, in_ready, stall, down_ready;
    logic              tile_valid, busy, done;
    logic [7:0]        in_x0, in_y0, in_x1, in_y1, pos_x, pos_y;
    logic [2:0][31:0]  in_corners, in_step_x, in_step_y, corners;
    logic [1:0]        fsm_state;

    gfx_raster_scan #(.COARSE_BITS(8), .EDGE_W(32), .FINE_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_x0(in_x0), .in_y0(in_y0), .in_x1(in_x1), .in_y1(in_y1),
        .in_corners(in_corners), .in_step_x(in_step_x), .in_step_y(in_step_y),
        .pos_x(pos_x), .pos_y(pos_y), .corners(corners), .stall(stall),
        .down_ready(down_ready), .tile_valid(tile_valid), .busy(busy),
        .done(done), .fsm_state(fsm_state)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: count of advances since the accept, plus the latched box.
    logic             m_any, m_done_now;
    int               m_a, m_n, m_d;
    logic [7:0]       m_x0, m_y0, m_x1, m_y1;
    logic [2:0][31:0] m_c, m_sx, m_sy;

    function automatic logic model_idle();
        return !m_any || (m_a >= m_d);
    endfunction

    task automatic model_reset();
        m_any = 1'b0; m_done_now = 1'b0; m_a = 0; m_n = 0; m_d = 0;
    endtask

    task automatic model_update(input logic dr, input logic iv);
        logic idle;
        int w, h;
        idle = model_idle();
        m_done_now = 1'b0;
        if (iv && idle) begin
            m_x0 = in_x0; m_y0 = in_y0; m_x1 = in_x1; m_y1 = in_y1;
            m_c = in_corners; m_sx = in_step_x; m_sy = in_step_y;
            m_any = 1'b1; m_a = 0;
            if (in_x1 < in_x0 || in_y1 < in_y0) m_n = 0;
            else begin
                w = int'(in_x1) - int'(in_x0) + 1;
                h = int'(in_y1) - int'(in_y0) + 1;
                m_n = w * h;
            end
            m_d = (m_n == 0) ? 1 : m_n + L;
        end else if (m_any && dr && m_a < m_d) begin
            m_a++;
            if (m_a == m_d) m_done_now = 1'b1;
        end
    endtask

    // Tile k of the box, in row-major order, with its edge values.
    task automatic model_tile(input int k, output logic [7:0] ex, output logic [7:0] ey,
                              output logic [2:0][31:0] ec);
        int w, dx, dy;
        w  = int'(m_x1) - int'(m_x0) + 1;
        dx = k % w;
        dy = k / w;
        ex = m_x0 + 8'(dx);
        ey = m_y0 + 8'(dy);
        for (int i = 0; i < 3; i++) ec[i] = m_c[i] + 32'(dx) * m_sx[i] + 32'(dy) * m_sy[i];
    endtask

    task automatic check_outputs();
        logic eb, etv;
        logic [7:0] ex, ey;
        logic [2:0][31:0] ec;
        eb  = !model_idle();
        etv = m_any && m_n > 0 && m_a >= L && m_a < m_n + L;
        if (!m_any) begin
            ex = 8'd0; ey = 8'd0; ec = '0;
        end else if (m_n == 0) begin
            ex = m_x0; ey = m_y0; ec = m_c;
        end else begin
            model_tile((m_a < m_n) ? m_a : m_n - 1, ex, ey, ec);
        end
        chk("in_ready", 64'(in_ready), 64'(!eb));
        chk("busy", 64'(busy), 64'(eb));
        chk("done", 64'(done), 64'(m_done_now));
        chk("tile_valid", 64'(tile_valid), 64'(etv));
        chk("stall", 64'(stall), 64'(!down_ready));
        chk("pos_x", 64'(pos_x), 64'(ex));
        chk("pos_y", 64'(pos_y), 64'(ey));
        for (int i = 0; i < 3; i++) chk($sformatf("corners%0d", i), 64'(corners[i]), 64'(ec[i]));
    endtask

    // Driver: one clock cycle with the given down_ready / in_valid.
    logic             s_tv, s_done, s_rdy;
    logic [7:0]       s_px, s_py;
    logic [2:0][31:0] s_c;

    task automatic cycle(input logic dr, input logic iv);
        down_ready = dr;
        in_valid   = iv;
        #1;
        check_outputs();
        s_tv = tile_valid; s_done = done; s_rdy = in_ready;
        s_px = pos_x; s_py = pos_y; s_c = corners;
        @(posedge clk);
        if (rst_n) model_update(dr, iv);
        #1;
    endtask

    task automatic set_tri(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1,
                           input logic [7:0] y1, input logic [2:0][31:0] c,
                           input logic [2:0][31:0] sx, input logic [2:0][31:0] sy);
        in_x0 = x0; in_y0 = y0; in_x1 = x1; in_y1 = y1;
        in_corners = c; in_step_x = sx; in_step_y = sy;
    endtask

    // Whole-triangle vectors: setup plus expected tile count, done cycle
    // (counted from the accept cycle) and the tile held at done.
    typedef struct {
        logic [7:0]       x0, y0, x1, y1;
        logic [2:0][31:0] c, sx, sy;
        int               n, done_at;
        logic [7:0]       lx, ly;
        logic [2:0][31:0] lc;
    } vec_t;

    vec_t tbl[7];

    task automatic apply_vec(input int idx, input logic dr_random);
        int tvc, done_at;
        logic [7:0] lx, ly;
        logic [2:0][31:0] lc;
        tvc = 0; done_at = -1; lx = 0; ly = 0; lc = '0;
        set_tri(tbl[idx].x0, tbl[idx].y0, tbl[idx].x1, tbl[idx].y1, tbl[idx].c, tbl[idx].sx, tbl[idx].sy);
        cycle(1'b1, 1'b1);
        for (int j = 1; j <= 40; j++) begin
            cycle(1'b1, 1'b0);
            if (s_tv) tvc++;
            if (s_done) begin
                done_at = j; lx = s_px; ly = s_py; lc = s_c;
                chk($sformatf("v%0d_ready_at_done", idx), 64'(s_rdy), 64'd1);
                break;
            end
        end
        chk($sformatf("v%0d_tiles", idx), 64'(tvc), 64'(tbl[idx].n));
        chk($sformatf("v%0d_done_at", idx), 64'(done_at), 64'(tbl[idx].done_at));
        chk($sformatf("v%0d_last_x", idx), 64'(lx), 64'(tbl[idx].lx));
        chk($sformatf("v%0d_last_y", idx), 64'(ly), 64'(tbl[idx].ly));
        for (int i = 0; i < 3; i++)
            chk($sformatf("v%0d_last_c%0d", idx, i), 64'(lc[i]), 64'(tbl[idx].lc[i]));
    endtask

    initial begin
        int done_at, budget;
        logic [7:0] rx0, ry0, rx1, ry1;
        logic [2:0][31:0] rc, rsx, rsy;

        tbl[0] = '{8'd2, 8'd3, 8'd3, 8'd4, {32'd0, 32'd20, 32'd100}, {32'd0, 32'd1, 32'd10},
                   {32'd0, 32'd2, 32'hFFFF_FFCE}, 4, 7, 8'd3, 8'd4, {32'd0, 32'd23, 32'd60}};
        tbl[1] = '{8'd7, 8'd7, 8'd7, 8'd7, {32'd3, 32'd2, 32'd5}, {32'd1, 32'd1, 32'd1},
                   {32'd1, 32'd1, 32'd1}, 1, 4, 8'd7, 8'd7, {32'd3, 32'd2, 32'd5}};
        tbl[2] = '{8'd5, 8'd0, 8'd4, 8'd0, {32'd0, 32'd0, 32'd9}, {32'd1, 32'd1, 32'd1},
                   {32'd1, 32'd1, 32'd1}, 0, 2, 8'd5, 8'd0, {32'd0, 32'd0, 32'd9}};
        tbl[3] = '{8'd0, 8'd3, 8'd0, 8'd2, {32'd1, 32'd2, 32'd3}, {32'd0, 32'd0, 32'd0},
                   {32'd0, 32'd0, 32'd0}, 0, 2, 8'd0, 8'd3, {32'd1, 32'd2, 32'd3}};
        tbl[4] = '{8'd254, 8'd0, 8'd255, 8'd0, {32'd0, 32'h7FFF_FFF0, 32'd0}, {32'd0, 32'h20, 32'd0},
                   {32'd0, 32'd0, 32'd0}, 2, 5, 8'd255, 8'd0, {32'd0, 32'h8000_0010, 32'd0}};
        tbl[5] = '{8'd0, 8'd0, 8'd2, 8'd1, {32'd0, 32'd0, 32'd1000}, {32'd0, 32'd0, 32'hFFFF_FFFF},
                   {32'd0, 32'd0, 32'h100}, 6, 9, 8'd2, 8'd1, {32'd0, 32'd0, 32'd1254}};
        tbl[6] = '{8'd255, 8'd255, 8'd255, 8'd255, {32'd5, 32'd4, 32'd3}, {32'd9, 32'd9, 32'd9},
                   {32'd9, 32'd9, 32'd9}, 1, 4, 8'd255, 8'd255, {32'd5, 32'd4, 32'd3}};

        // Reset.
        model_reset();
        rst_n = 1'b0; in_valid = 1'b0; down_ready = 1'b1;
        set_tri(8'd0, 8'd0, 8'd0, 8'd0, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;

        // Table-driven triangles.
        for (int v = 0; v < 7; v++) apply_vec(v, 1'b0);

        // Backpressure: stall three cycles after the second issue.
        set_tri(tbl[0].x0, tbl[0].y0, tbl[0].x1, tbl[0].y1, tbl[0].c, tbl[0].sx, tbl[0].sy);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        done_at = -1;
        for (int j = 3; j <= 5; j++) begin
            cycle(1'b0, 1'b0);
            chk("bp_hold_x", 64'(s_px), 64'd2);
            chk("bp_hold_y", 64'(s_py), 64'd4);
        end
        for (int j = 6; j <= 40; j++) begin
            cycle(1'b1, 1'b0);
            if (s_done) begin done_at = j; break; end
        end
        chk("bp_done_at", 64'(done_at), 64'd10);

        // Reset in the middle of a walk.
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pos_x", 64'(pos_x), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_corners", 64'(corners[0]), 64'd0);
        check_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int j = 0; j < 6; j++) cycle(1'b1, 1'b0);
        apply_vec(4, 1'b0);

        // Back-to-back: in_valid stays high; the second setup is presented once the first is done.
        set_tri(tbl[0].x0, tbl[0].y0, tbl[0].x1, tbl[0].y1, tbl[0].c, tbl[0].sx, tbl[0].sy);
        cycle(1'b1, 1'b1);
        done_at = -1;
        for (int j = 1; j <= 40; j++) begin
            if (model_idle())
                set_tri(tbl[5].x0, tbl[5].y0, tbl[5].x1, tbl[5].y1, tbl[5].c, tbl[5].sx, tbl[5].sy);
            cycle(1'b1, 1'b1);
            if (s_done) begin
                done_at = j;
                chk("b2b_ready_at_done", 64'(s_rdy), 64'd1);
                break;
            end
        end
        chk("b2b_done_at", 64'(done_at), 64'd7);
        cycle(1'b1, 1'b0);
        chk("b2b_second_first_x", 64'(s_px), 64'd0);
        chk("b2b_second_busy", 64'(busy), 64'd1);
        budget = 0;
        while (!model_idle() && budget < 60) begin cycle(1'b1, 1'b0); budget++; end
        chk("b2b_second_finished", 64'(model_idle()), 64'd1);

        // Random triangles with random backpressure.
        for (int t = 0; t < 30; t++) begin
            rx0 = 8'($urandom_range(0, 255));
            ry0 = 8'($urandom_range(0, 255));
            rx1 = (int'(rx0) + 3 > 255) ? 8'd255 : rx0 + 8'($urandom_range(0, 3));
            ry1 = (int'(ry0) + 2 > 255) ? 8'd255 : ry0 + 8'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0 && rx0 != 8'd0) rx1 = rx0 - 8'd1;
            for (int i = 0; i < 3; i++) begin
                rc[i] = $urandom; rsx[i] = $urandom; rsy[i] = $urandom;
            end
            set_tri(rx0, ry0, rx1, ry1, rc, rsx, rsy);
            cycle(1'($urandom_range(0, 3) != 0), 1'b1);
            budget = 0;
            while (!model_idle() && budget < 200) begin
                cycle(1'($urandom_range(0, 3) != 0), model_idle() ? 1'b0 : 1'($urandom_range(0, 1)));
                budget++;
            end
            chk("rand_finished", 64'(model_idle()), 64'd1);
            cycle(1'($urandom_range(0, 1)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
